// File: rtl/pc_predict_ctrl_if.sv
// Pipeline-side bundle for the PC/predictor controller: decode and execute branch
// slots, execute-stage flags, and the prediction/flush results returned to the pipe.
interface pc_predict_ctrl_if #(
    parameter int PC_W  = 16,
    parameter int IMM_W = 9
);
    logic             dec_valid;
    logic             dec_is_branch;
    logic [2:0]       dec_ccc;
    logic [IMM_W-1:0] dec_imm;
    logic [PC_W-1:0]  dec_pc;
    logic             dec_pred_taken;

    logic             ex_valid;
    logic             ex_is_branch;
    logic [2:0]       ex_ccc;
    logic [IMM_W-1:0] ex_imm;
    logic [PC_W-1:0]  ex_pc;
    logic             ex_pred_taken;
    logic [2:0]       flags;

    logic             flush_if;
    logic             flush_id;

    modport master (
        output dec_valid, dec_is_branch, dec_ccc, dec_imm, dec_pc,
        output ex_valid, ex_is_branch, ex_ccc, ex_imm, ex_pc, ex_pred_taken, flags,
        input  dec_pred_taken, flush_if, flush_id
    );

    modport slave (
        input  dec_valid, dec_is_branch, dec_ccc, dec_imm, dec_pc,
        input  ex_valid, ex_is_branch, ex_ccc, ex_imm, ex_pc, ex_pred_taken, flags,
        output dec_pred_taken, flush_if, flush_id
    );
endinterface

// File: rtl/pc_predict_ctrl.sv
// Fetch PC generator with a bimodal (2-bit counter) branch predictor; predicts in
// decode, resolves in execute against {N,V,Z}, redirects fetch and flushes on mispredict.
module pc_predict_ctrl #(
    parameter int              PC_W        = 16,
    parameter int              IMM_W       = 9,
    parameter int              BHT_ENTRIES = 16,
    parameter logic [PC_W-1:0] RESET_PC    = '0,
    parameter int              CNT_W       = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    output logic [PC_W-1:0]    pc,
    output logic [CNT_W-1:0]   mispredict_cnt,
    pc_predict_ctrl_if.slave   bus
);
    localparam int              IDX_W = $clog2(BHT_ENTRIES);
    localparam logic [PC_W-1:0] PC_INC = PC_W'(2);

    function automatic logic [PC_W-1:0] branch_target(input logic [PC_W-1:0] base,
                                                      input logic [IMM_W-1:0] imm);
        logic [PC_W-1:0] offset;
        offset = {{(PC_W-IMM_W){imm[IMM_W-1]}}, imm} << 1;
        return base + PC_INC + offset;
    endfunction

    function automatic logic cond_taken(input logic [2:0] ccc, input logic [2:0] f);
        logic n, v, z;
        logic res;
        n = f[2];
        v = f[1];
        z = f[0];
        unique case (ccc)
            3'b000:  res = ~z;
            3'b001:  res = z;
            3'b010:  res = ~z & ~n;
            3'b011:  res = n;
            3'b100:  res = z | ~n;
            3'b101:  res = n | z;
            3'b110:  res = v;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] dec_idx;
    logic [IDX_W-1:0] ex_idx;
    logic             dec_pred;
    logic             ex_resolve;
    logic             ex_actual;
    logic             mispredict;
    logic             dec_redirect;
    logic [PC_W-1:0]  correct_pc;
    logic [PC_W-1:0]  pc_next;
    logic [1:0]       bht_upd;

    assign dec_idx = bus.dec_pc[IDX_W:1];
    assign ex_idx  = bus.ex_pc[IDX_W:1];

    always_comb begin
        dec_pred     = bus.dec_valid & bus.dec_is_branch &
                       ((bus.dec_ccc == 3'b111) | bht[dec_idx][1]);
        ex_resolve   = bus.ex_valid & bus.ex_is_branch;
        ex_actual    = cond_taken(bus.ex_ccc, bus.flags);
        mispredict   = ex_resolve & (ex_actual != bus.ex_pred_taken);
        // An execute mispredict squashes the decode slot, so its redirect is void.
        dec_redirect = dec_pred & ~stall & ~mispredict;
        correct_pc   = ex_actual ? branch_target(bus.ex_pc, bus.ex_imm) : bus.ex_pc + PC_INC;

        pc_next = pc + PC_INC;
        if (mispredict) begin
            pc_next = correct_pc;
        end else if (dec_redirect) begin
            pc_next = branch_target(bus.dec_pc, bus.dec_imm);
        end else if (stall) begin
            pc_next = pc;
        end

        bht_upd = bht[ex_idx];
        if (ex_actual) begin
            if (bht[ex_idx] != 2'b11) bht_upd = bht[ex_idx] + 2'd1;
        end else begin
            if (bht[ex_idx] != 2'b00) bht_upd = bht[ex_idx] - 2'd1;
        end
    end

    assign bus.dec_pred_taken = dec_pred;
    assign bus.flush_if       = mispredict | dec_redirect;
    assign bus.flush_id       = mispredict;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            mispredict_cnt <= '0;
        end else begin
            pc <= pc_next;
            if (mispredict && (mispredict_cnt != {CNT_W{1'b1}})) begin
                mispredict_cnt <= mispredict_cnt + CNT_W'(1);
            end
        end
    end

    // Unconditional branches are always predicted taken, so they never train the table.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (ex_resolve && (bus.ex_ccc != 3'b111)) begin
            bht[ex_idx] <= bht_upd;
        end
    end
endmodule

// File: tb/tb_pc_predict_ctrl.sv
// Directed bench for pc_predict_ctrl: hand-computed PC, flush, prediction and
// mispredict-count expectations, including wrap-around and reset during a redirect.
module tb_pc_predict_ctrl;
    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [15:0] pc;
    logic [15:0] mispredict_cnt;
    int          tests_run;
    int          tests_failed;
    logic [6:0]  cond_vec [10];

    pc_predict_ctrl_if #(.PC_W(16), .IMM_W(9)) bus ();

    pc_predict_ctrl #(
        .PC_W(16), .IMM_W(9), .BHT_ENTRIES(16), .RESET_PC(16'h0100), .CNT_W(16)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .stall(stall),
        .pc(pc),
        .mispredict_cnt(mispredict_cnt),
        .bus(bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic st,
                                 input logic dv, input logic db, input logic [2:0] dc,
                                 input logic [8:0] di, input logic [15:0] dp,
                                 input logic ev, input logic eb, input logic [2:0] ec,
                                 input logic [8:0] ei, input logic [15:0] ep,
                                 input logic ept, input logic [2:0] fl);
        stall             = st;
        bus.dec_valid     = dv;
        bus.dec_is_branch = db;
        bus.dec_ccc       = dc;
        bus.dec_imm       = di;
        bus.dec_pc        = dp;
        bus.ex_valid      = ev;
        bus.ex_is_branch  = eb;
        bus.ex_ccc        = ec;
        bus.ex_imm        = ei;
        bus.ex_pc         = ep;
        bus.ex_pred_taken = ept;
        bus.flags         = fl;
        #1;
    endtask

    task automatic idle();
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 0,0,3'd0,9'd0,16'h0,0,3'b000);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        // {ccc, flags{N,V,Z}, expected taken}
        cond_vec = '{7'b000_000_1, 7'b001_000_0, 7'b010_100_0, 7'b011_100_1,
                     7'b100_101_1, 7'b101_010_0, 7'b110_010_1, 7'b111_000_1,
                     7'b100_100_0, 7'b010_000_1};

        rst_n = 1'b0;
        idle();
        #11;
        checkOutput("rst_pc", 32'(pc), 32'h0100);
        checkOutput("rst_cnt", 32'(mispredict_cnt), 32'h0);
        checkOutput("rst_flush_if", 32'(bus.flush_if), 32'h0);
        checkOutput("rst_flush_id", 32'(bus.flush_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 4; i++) begin
            checkOutput("seq_pc", 32'(pc), 32'h0100 + 32'(2 * i));
            checkOutput("seq_flush_if", 32'(bus.flush_if), 32'h0);
            step();
        end

        // Unconditional decode branch backwards by one word
        applyStimulus(0, 1,1,3'b111,9'h1FE,16'h0010, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("dec_pred_uncond", 32'(bus.dec_pred_taken), 32'h1);
        checkOutput("dec_flush_if", 32'(bus.flush_if), 32'h1);
        checkOutput("dec_flush_id", 32'(bus.flush_id), 32'h0);
        step();
        checkOutput("dec_redirect_pc", 32'(pc), 32'h000E);
        idle();

        // Execute mispredict, predicted not taken but Z=1
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,3'b001,9'd4,16'h0020,0,3'b001);
        checkOutput("ex_flush_if", 32'(bus.flush_if), 32'h1);
        checkOutput("ex_flush_id", 32'(bus.flush_id), 32'h1);
        step();
        checkOutput("ex_redirect_pc", 32'(pc), 32'h002A);
        checkOutput("ex_cnt1", 32'(mispredict_cnt), 32'h1);
        applyStimulus(0, 1,1,3'b000,9'd0,16'h0020, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("bht_10_pred", 32'(bus.dec_pred_taken), 32'h1);

        // Two correctly predicted taken resolutions saturate the counter
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,3'b001,9'd4,16'h0020,1,3'b001);
        checkOutput("ex_correct_noflush", 32'(bus.flush_if), 32'h0);
        step();
        step();
        checkOutput("ex_correct_pc", 32'(pc), 32'h002E);
        applyStimulus(0, 1,1,3'b000,9'd0,16'h0020, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("bht_11_pred", 32'(bus.dec_pred_taken), 32'h1);

        // Two not-taken resolutions bring it back to weakly not taken
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,3'b001,9'd4,16'h0020,1,3'b000);
        checkOutput("nt1_flush_id", 32'(bus.flush_id), 32'h1);
        step();
        checkOutput("nt1_pc", 32'(pc), 32'h0022);
        applyStimulus(0, 1,1,3'b000,9'd0,16'h0020, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("bht_10b_pred", 32'(bus.dec_pred_taken), 32'h1);
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,3'b001,9'd4,16'h0020,1,3'b000);
        step();
        checkOutput("nt2_pc", 32'(pc), 32'h0022);
        applyStimulus(0, 1,1,3'b000,9'd0,16'h0020, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("bht_01_pred", 32'(bus.dec_pred_taken), 32'h0);
        checkOutput("nt_cnt3", 32'(mispredict_cnt), 32'h3);

        // Same-cycle read and update of one entry: decode sees the old value
        applyStimulus(0, 1,1,3'b000,9'd0,16'h0020, 1,1,3'b001,9'd4,16'h0020,1,3'b001);
        checkOutput("rw_same_pred", 32'(bus.dec_pred_taken), 32'h0);
        checkOutput("rw_same_flush", 32'(bus.flush_if), 32'h0);
        step();
        checkOutput("rw_same_pc", 32'(pc), 32'h0024);
        applyStimulus(0, 1,1,3'b000,9'd0,16'h0020, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("rw_after_pred", 32'(bus.dec_pred_taken), 32'h1);

        // Stalled decode prediction does not redirect
        applyStimulus(1, 1,1,3'b111,9'd5,16'h0100, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("stall_pred", 32'(bus.dec_pred_taken), 32'h1);
        checkOutput("stall_flush_if", 32'(bus.flush_if), 32'h0);
        step();
        checkOutput("stall_hold_pc", 32'(pc), 32'h0024);

        // Execute mispredict beats decode redirect and stall
        applyStimulus(1, 1,1,3'b111,9'd5,16'h0100, 1,1,3'b111,9'd0,16'h003E,0,3'b000);
        checkOutput("prio_flush_if", 32'(bus.flush_if), 32'h1);
        checkOutput("prio_flush_id", 32'(bus.flush_id), 32'h1);
        step();
        checkOutput("prio_pc", 32'(pc), 32'h0040);
        checkOutput("prio_cnt", 32'(mispredict_cnt), 32'h4);

        // Wrap-around of sequential and target arithmetic
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,3'b111,9'd0,16'hFFFC,0,3'b000);
        step();
        checkOutput("wrap_setup_pc", 32'(pc), 32'hFFFE);
        idle();
        step();
        checkOutput("wrap_seq_pc", 32'(pc), 32'h0000);
        applyStimulus(0, 1,1,3'b111,9'd3,16'hFFFC, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        step();
        checkOutput("wrap_target_pc", 32'(pc), 32'h0004);

        // V=0 on a branch predicted taken falls through
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,3'b110,9'd3,16'h0050,1,3'b000);
        checkOutput("vclr_flush_id", 32'(bus.flush_id), 32'h1);
        step();
        checkOutput("vclr_pc", 32'(pc), 32'h0052);
        checkOutput("vclr_cnt", 32'(mispredict_cnt), 32'h6);

        // Invalid slots have no effect
        applyStimulus(0, 0,1,3'b111,9'd5,16'h0100, 0,1,3'b111,9'd0,16'h003E,0,3'b000);
        checkOutput("inv_pred", 32'(bus.dec_pred_taken), 32'h0);
        checkOutput("inv_flush_if", 32'(bus.flush_if), 32'h0);
        checkOutput("inv_flush_id", 32'(bus.flush_id), 32'h0);
        step();
        checkOutput("inv_pc", 32'(pc), 32'h0054);
        checkOutput("inv_cnt", 32'(mispredict_cnt), 32'h6);

        // Condition decoding, observed as a mispredict against a not-taken guess
        for (int i = 0; i < 10; i++) begin
            applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,cond_vec[i][6:4],9'd0,16'h0060,0,
                          cond_vec[i][3:1]);
            checkOutput($sformatf("cond_%0d", i), 32'(bus.flush_id), 32'(cond_vec[i][0]));
        end

        // Reset asserted while a redirect is pending
        applyStimulus(0, 0,0,3'd0,9'd0,16'h0, 1,1,3'b111,9'd0,16'h003E,0,3'b000);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_pc", 32'(pc), 32'h0100);
        checkOutput("midrst_cnt", 32'(mispredict_cnt), 32'h0);
        checkOutput("midrst_flush_id", 32'(bus.flush_id), 32'h1);
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        step();
        checkOutput("postrst_pc", 32'(pc), 32'h0102);
        applyStimulus(0, 1,1,3'b000,9'd0,16'h0020, 0,0,3'd0,9'd0,16'h0,0,3'b000);
        checkOutput("postrst_bht_pred", 32'(bus.dec_pred_taken), 32'h0);
        idle();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/pc_predict_ctrl.md
# pc_predict_ctrl

Registered program-counter generator with a parametrised bimodal branch predictor for the 16-bit pipelined core. It owns the fetch PC, predicts conditional branches in decode from a table of 2-bit saturating counters, resolves branches in execute against the N/V/Z flags, and redirects fetch and issues flushes on mispredict. It sits between the fetch stage, the decode stage and the execute-stage flag register.

## Interface
- PC_W, 16, PC and address width.
- IMM_W, 9, branch immediate width (signed, in instruction words).
- BHT_ENTRIES, 16, predictor entries (power of two, ≥2); index = pc[log2(BHT_ENTRIES):1].
- RESET_PC, 0, PC value after reset.
- CNT_W, 16, width of mispredict statistics counter.

- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold fetch PC (hazard unit).
- pc  out  PC_W  current fetch PC (registered).
- dec_valid  in  1  decode slot holds a valid instruction.
- dec_is_branch  in  1  decode instruction is a conditional/unconditional branch.
- dec_ccc  in  3  decode branch condition code.
- dec_imm  in  IMM_W  decode branch immediate.
- dec_pc  in  PC_W  PC of decode instruction.
- dec_pred_taken  out  1  prediction for decode branch; pipelined to execute by the core.
- ex_valid  in  1  execute slot valid.
- ex_is_branch  in  1  execute instruction is a branch.
- ex_ccc  in  3  execute condition code.
- ex_imm  in  IMM_W  execute immediate.
- ex_pc  in  PC_W  PC of execute instruction.
- ex_pred_taken  in  1  prediction carried from decode.
- flags  in  3  {N, V, Z}: flags[2]=N, flags[1]=V, flags[0]=Z.
- flush_if  out  1  kill instruction in fetch.
- flush_id  out  1  kill instruction in decode.
- mispredict_cnt  out  CNT_W  saturating count of mispredicts.

## Operation
- Target = (pc_in + 2) + (sext(imm) << 1), modulo 2^PC_W; fall-through = pc_in + 2, modulo 2^PC_W.
- Conditions (taken when): 000 Z=0; 001 Z=1; 010 Z=0 and N=0; 011 N=1; 100 Z=1 or N=0; 101 N=1 or Z=1; 110 V=1; 111 always.
- Decode prediction: dec_pred_taken = dec_valid & dec_is_branch & (ccc==111 | bht[idx(dec_pc)][1]); combinational.
- Execute resolution (ex_valid & ex_is_branch): actual = condition(ex_ccc, flags); mispredict = actual != ex_pred_taken; correct PC = actual ? target(ex_pc, ex_imm) : ex_pc + 2.
- Next-PC priority: (1) execute mispredict → correct PC; (2) dec_pred_taken & ~stall → target(dec_pc, dec_imm); (3) stall → hold; (4) pc + 2.
- Flushes (combinational): mispredict → flush_if=1, flush_id=1; decode redirect (priority 2 active) → flush_if=1, flush_id=0; otherwise both 0.
- BHT update on every resolved branch with ex_ccc≠111: taken → counter+1 saturating at 11; not taken → counter−1 saturating at 00. ccc=111 never updates.
- Same-cycle read and write to one entry: decode reads the pre-update value (no bypass).
- mispredict_cnt increments by 1 per mispredict, saturates at all-ones.

## Timing
- Reset (async, rst_n=0): pc=RESET_PC, all BHT counters=01 (weakly not taken), mispredict_cnt=0. Combinational outputs follow inputs; pc/BHT/counter held during reset.
- Redirect latency: pc takes new value on the clk edge ending the redirecting cycle (1 cycle).
- Execute mispredict overrides stall and decode redirect in the same cycle.
- Invalid slots (dec_valid=0 / ex_valid=0) cause no prediction, update, or flush.
- Wrap-around: pc=0xFFFE sequential → 0x0000; target arithmetic wraps identically.
- Reset asserted mid-redirect: reset wins, pc=RESET_PC immediately.

## Test plan
- Reset with RESET_PC=0x0100, no branches, 4 cycles → pc 0x0100, 0x0102, 0x0104, 0x0106; flushes 0; mispredict_cnt 0.
- Decode ccc=111, dec_pc=0x0010, imm=0x1FE (−2), stall=0 → dec_pred_taken=1, flush_if=1, next pc=0x000E.
- Execute ccc=001, Z=1, ex_pred_taken=0, ex_pc=0x0020, imm=4 → flush_if=flush_id=1, next pc=0x002A, counter 01→10, mispredict_cnt=1.
- Same entry resolved taken twice more → counter saturates 11; decode at that PC with ccc=000 predicts taken; two not-taken resolutions → 01, prediction not-taken.
- Simultaneous execute mispredict (correct PC 0x0040), decode taken prediction and stall=1 → next pc=0x0040, flush_id=1.
- pc=0xFFFE, no events → pc 0x0000; ccc=110 with V=0 predicted taken → mispredict, next pc=ex_pc+2.
